branch_predict_ctrl: RTL

Controller that sequences the 2-bit branch-prediction counters for the rv32 pipeline. It holds a 2^IDX_W-entry saturating-counter table, answers fetch-stage lookups, and tracks in-flight predictions in a small FIFO. It pairs each execute-stage resolution with the oldest outstanding prediction, trains the counter, and raises a one-cycle flush on a mispredict. It sits between the fetch unit (lookup side) and the execute unit (resolve side).

---
 rtl/branch_predict_ctrl_pkg.sv | 32 +++
 rtl/branch_predict_ctrl_counter_table.sv | 33 +++
 rtl/branch_predict_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types for the branch-prediction controller: counter encodings,
// controller states and the in-flight prediction record.
package branch_predict_ctrl_pkg;

    localparam int unsigned BP_IDX_W = 6;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_e;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        FLUSH
    } bp_state_e;

    typedef struct packed {
        logic [BP_IDX_W-1:0] idx;
        logic                pred;
    } bp_inflight_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr + 2'd1;
        end
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predict_ctrl_counter_table.sv
// 2-bit saturating counter table: async read, one training write port and
// an initialisation write port that takes priority.
module bp_counter_table
    import branch_predict_ctrl_pkg::*;
#(
    parameter int unsigned IDX_W = BP_IDX_W
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_ctr,
    input  logic             i_upd_en,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken,
    input  logic             i_init_en,
    input  logic [IDX_W-1:0] i_init_idx
);

    localparam int unsigned ENTRIES = 1 << IDX_W;

    logic [1:0] r_ctr [ENTRIES];

    // No bypass: a lookup racing a write to the same entry sees the old value.
    assign o_rd_ctr = r_ctr[i_rd_idx];

    always_ff @(posedge clk) begin
        if (i_init_en) begin
            r_ctr[i_init_idx] <= WNT;
        end else if (i_upd_en) begin
            r_ctr[i_upd_idx] <= ctr_next(r_ctr[i_upd_idx], i_upd_taken);
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch-prediction controller: table init sequencing, in-flight prediction
// FIFO, resolve/train handling, mispredict flush and statistics.
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int unsigned IDX_W = BP_IDX_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lkp_valid,
    input  logic [IDX_W-1:0] lkp_idx,
    output logic             lkp_ready,
    output logic             lkp_predict,
    input  logic             res_valid,
    input  logic             res_taken,
    output logic             flush,
    output logic             redirect_taken,
    output logic             res_err,
    output logic [15:0]      mispredict_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             pred;
    } inflight_t;

    bp_state_e        r_state;
    logic [IDX_W-1:0] r_init_idx;
    inflight_t        r_fifo [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_flush;
    logic             r_redirect;
    logic             r_res_err;
    logic [15:0]      r_mcnt;

    logic [1:0]       w_rd_ctr;
    inflight_t        w_head;
    inflight_t        w_new;
    logic             w_run;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_mispred;
    logic             w_empty_res;

    bp_counter_table #(
        .IDX_W(IDX_W)
    ) u_table (
        .clk        (clk),
        .i_rd_idx   (lkp_idx),
        .o_rd_ctr   (w_rd_ctr),
        .i_upd_en   (w_pop),
        .i_upd_idx  (w_head.idx),
        .i_upd_taken(res_taken),
        .i_init_en  (r_state == INIT),
        .i_init_idx (r_init_idx)
    );

    assign w_run       = (r_state == RUN);
    assign w_full      = (r_count == FULL_CNT);
    assign lkp_ready   = w_run && !w_full;
    assign lkp_predict = w_rd_ctr[1];
    assign w_push      = lkp_valid && lkp_ready;
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_pop       = w_run && res_valid && (r_count != '0);
    assign w_empty_res = w_run && res_valid && (r_count == '0);
    assign w_mispred   = w_pop && (w_head.pred != res_taken);
    assign w_new       = '{idx: lkp_idx, pred: lkp_predict};

    assign flush          = r_flush;
    assign redirect_taken = r_redirect;
    assign res_err        = r_res_err;
    assign mispredict_cnt = r_mcnt;

    // Storage needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push && !w_mispred) begin
            r_fifo[r_wr_ptr] <= w_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= INIT;
            r_init_idx <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_flush    <= 1'b0;
            r_redirect <= 1'b0;
            r_res_err  <= 1'b0;
            r_mcnt     <= '0;
        end else begin
            r_flush   <= w_mispred;
            r_res_err <= w_empty_res;
            case (r_state)
                INIT: begin
                    r_init_idx <= r_init_idx + 1'b1;
                    if (r_init_idx == '1) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_mispred) begin
                        // A push in the mispredicting cycle is dropped with the rest.
                        r_state    <= FLUSH;
                        r_redirect <= res_taken;
                        if (r_mcnt != '1) begin
                            r_mcnt <= r_mcnt + 1'b1;
                        end
                        r_wr_ptr <= '0;
                        r_rd_ptr <= '0;
                        r_count  <= '0;
                    end else begin
                        if (w_push) begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                        if (w_pop) begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                        case ({w_push, w_pop})
                            2'b10:   r_count <= r_count + 1'b1;
                            2'b01:   r_count <= r_count - 1'b1;
                            default: r_count <= r_count;
                        endcase
                    end
                end
                FLUSH: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

endmodule
